// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared state encoding, widths and parameter defaults for the
//               fabric reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_RETRY     = 3'd5
  } state_e;

  localparam int c_LOCK_CNT_W = 8;

  localparam int c_NUM_LOCKS_DEF     = 2;
  localparam int c_NUM_STAGES_DEF    = 3;
  localparam int c_FILTER_CYCLES_DEF = 256;
  localparam int c_STAGE_GAP_DEF     = 16;
  localparam int c_LOCK_TIMEOUT_DEF  = 65536;
  localparam int c_RETRY_PULSE_DEF   = 64;

  // Counter width able to hold 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_seq_sync.sv
// ============================================================================
// Module      : reset_seq_sync
// Description : Parametrised-width 2-flop synchroniser with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/reset_sequencer_pf.sv
// ============================================================================
// Module      : reset_sequencer_pf
// Description : Fabric reset sequencer: merges POR/ext reset, init-done and PLL
//               locks, filters the locks and releases ordered reset stages.
//               Optional PLL timeout/retry enabled by RESET_SEQ_PLL_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer_pf
  import reset_seq_pkg::*;
#(
  parameter int NUM_LOCKS     = c_NUM_LOCKS_DEF,
  parameter int NUM_STAGES    = c_NUM_STAGES_DEF,
  parameter int FILTER_CYCLES = c_FILTER_CYCLES_DEF,
  parameter int STAGE_GAP     = c_STAGE_GAP_DEF,
  parameter int LOCK_TIMEOUT  = c_LOCK_TIMEOUT_DEF,
  parameter int RETRY_PULSE   = c_RETRY_PULSE_DEF
) (
  input  logic                    CLK,
  input  logic                    EXT_RST_N,
  input  logic                    FPGA_POR_N,
  input  logic                    INIT_DONE,
  input  logic [NUM_LOCKS-1:0]    PLL_LOCK,
  input  logic                    SW_RST_REQ,
  output logic [NUM_STAGES-1:0]   FABRIC_RESET_N,
  output logic                    ALL_RELEASED,
  output logic                    PLL_POWERDOWN_B,
  output logic [c_LOCK_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [2:0]              STATE
);

  localparam int c_FILT_W = cnt_width(FILTER_CYCLES);
  localparam int c_GAP_W  = cnt_width(STAGE_GAP);

  localparam logic [c_FILT_W-1:0]     c_FILT_LAST   = c_FILT_W'(FILTER_CYCLES - 1);
  localparam logic [c_GAP_W-1:0]      c_GAP_LAST    = c_GAP_W'(STAGE_GAP - 1);
  localparam logic [NUM_STAGES-1:0]   c_STAGE_FIRST = NUM_STAGES'(1);
  localparam logic [c_LOCK_CNT_W-1:0] c_LLC_MAX     = '1;
  localparam bit                      c_ONE_STAGE   = (NUM_STAGES == 1);

  if (NUM_LOCKS < 1 || NUM_STAGES < 1 || FILTER_CYCLES < 1 || STAGE_GAP < 1 ||
      LOCK_TIMEOUT < 1 || RETRY_PULSE < 1) begin : g_bad_params
    $error("reset_sequencer_pf: all size parameters must be >= 1");
  end

  logic                    w_rst_n;
  logic [NUM_LOCKS-1:0]    w_lock_sync;
  logic [0:0]              w_init_sync;
  logic                    w_lock_ok;
  logic                    w_init_ok;
  logic [NUM_STAGES-1:0]   w_fab_next;

  state_e                  r_state;
  logic [NUM_STAGES-1:0]   r_fabric;
  logic                    r_all;
  logic [c_LOCK_CNT_W-1:0] r_llc;
  logic [c_FILT_W-1:0]     r_fcnt;
  logic [c_GAP_W-1:0]      r_gcnt;

  assign w_rst_n = EXT_RST_N & FPGA_POR_N;

  reset_seq_sync #(.WIDTH(NUM_LOCKS)) u_lock_sync (
    .clk   (CLK),
    .rst_n (w_rst_n),
    .i_d   (PLL_LOCK),
    .o_q   (w_lock_sync)
  );

  reset_seq_sync #(.WIDTH(1)) u_init_sync (
    .clk   (CLK),
    .rst_n (w_rst_n),
    .i_d   (INIT_DONE),
    .o_q   (w_init_sync)
  );

  assign w_lock_ok  = &w_lock_sync;
  assign w_init_ok  = w_init_sync[0];
  assign w_fab_next = (r_fabric << 1) | c_STAGE_FIRST;

`ifdef RESET_SEQ_PLL_RETRY_EN
  localparam int c_TO_W = cnt_width(LOCK_TIMEOUT);
  localparam int c_RP_W = cnt_width(RETRY_PULSE);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_RP_W-1:0] c_RP_LAST = c_RP_W'(RETRY_PULSE - 1);

  logic              r_pd_b;
  logic [c_TO_W-1:0] r_tcnt;
  logic [c_RP_W-1:0] r_rcnt;
`endif

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_WAIT_INIT;
      r_fabric <= '0;
      r_all    <= 1'b0;
      r_llc    <= '0;
      r_fcnt   <= '0;
      r_gcnt   <= '0;
`ifdef RESET_SEQ_PLL_RETRY_EN
      r_pd_b   <= 1'b1;
      r_tcnt   <= '0;
      r_rcnt   <= '0;
`endif
    end else if (!w_init_ok && r_state != ST_WAIT_INIT) begin
      // Losing init-done outranks everything and is never counted.
      r_state  <= ST_WAIT_INIT;
      r_fabric <= '0;
      r_all    <= 1'b0;
`ifdef RESET_SEQ_PLL_RETRY_EN
      r_pd_b   <= 1'b1;
`endif
    end else if ((r_state == ST_RELEASE || r_state == ST_RUN) &&
                 (!w_lock_ok || SW_RST_REQ)) begin
      r_state  <= ST_WAIT_LOCK;
      r_fabric <= '0;
      r_all    <= 1'b0;
      if (!w_lock_ok && r_llc != c_LLC_MAX)
        r_llc <= r_llc + 1'b1;
`ifdef RESET_SEQ_PLL_RETRY_EN
      r_tcnt   <= '0;
`endif
    end else begin
      case (r_state)
        ST_WAIT_INIT: begin
          if (w_init_ok) begin
            r_state <= ST_WAIT_LOCK;
`ifdef RESET_SEQ_PLL_RETRY_EN
            r_tcnt  <= '0;
`endif
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_ok) begin
            r_state <= ST_FILTER;
            r_fcnt  <= '0;
          end
`ifdef RESET_SEQ_PLL_RETRY_EN
          else if (r_tcnt == c_TO_LAST) begin
            r_state <= ST_RETRY;
            r_pd_b  <= 1'b0;
            r_rcnt  <= '0;
          end else begin
            r_tcnt  <= r_tcnt + 1'b1;
          end
`endif
        end
        ST_FILTER: begin
          if (!w_lock_ok) begin
            r_state <= ST_WAIT_LOCK;
`ifdef RESET_SEQ_PLL_RETRY_EN
            r_tcnt  <= '0;
`endif
          end else if (r_fcnt == c_FILT_LAST) begin
            r_fabric <= c_STAGE_FIRST;
            r_gcnt   <= '0;
            if (c_ONE_STAGE) begin
              r_state <= ST_RUN;
              r_all   <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
            end
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (r_gcnt == c_GAP_LAST) begin
            r_gcnt   <= '0;
            r_fabric <= w_fab_next;
            if (&w_fab_next) begin
              r_state <= ST_RUN;
              r_all   <= 1'b1;
            end
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
`ifdef RESET_SEQ_PLL_RETRY_EN
        ST_RETRY: begin
          // Locks are deliberately not looked at until the pulse completes.
          if (r_rcnt == c_RP_LAST) begin
            r_state <= ST_WAIT_LOCK;
            r_pd_b  <= 1'b1;
            r_tcnt  <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
`endif
        default: begin
          r_state  <= ST_WAIT_INIT;
          r_fabric <= '0;
          r_all    <= 1'b0;
        end
      endcase
    end
  end

  assign FABRIC_RESET_N = r_fabric;
  assign ALL_RELEASED   = r_all;
  assign LOCK_LOSS_CNT  = r_llc;
  assign STATE          = r_state;

`ifdef RESET_SEQ_PLL_RETRY_EN
  assign PLL_POWERDOWN_B = r_pd_b;
`else
  assign PLL_POWERDOWN_B = 1'b1;
`endif

endmodule

`default_nettype wire
